// File: rtl/answer_byte_streamer.sv
// Answer-path transmitter: optional 4-byte little-endian length header, then the
// payload bytes read from answer-buffer words, LSB byte first, onto the UART TX interface.
module answer_byte_streamer #(
    parameter int unsigned WORD_WIDTH = 32,
    parameter bit          HEADER_EN  = 1'b1
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  start,
    input  logic [31:0]           answer_size_in_bytes,
    input  logic [WORD_WIDTH-1:0] word_data,
    input  logic                  word_valid,
    output logic                  word_ready,
    output logic [7:0]            tx_data,
    output logic                  tx_valid,
    input  logic                  tx_ready,
    output logic                  busy,
    output logic                  done
);

    localparam int unsigned BytesPerWord = WORD_WIDTH / 8;
    localparam int unsigned IdxW         = $clog2(BytesPerWord + 1);

    typedef enum logic [2:0] {StIdle, StHdr, StLoad, StSend, StDone} state_e;

    state_e                state_q, state_d;
    logic [31:0]           size_q, size_d;
    logic [31:0]           remaining_q, remaining_d;
    logic [1:0]            hdr_cnt_q, hdr_cnt_d;
    logic [IdxW-1:0]       byte_idx_q, byte_idx_d;
    logic [WORD_WIDTH-1:0] shift_q, shift_d;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q     <= StIdle;
            size_q      <= '0;
            remaining_q <= '0;
            hdr_cnt_q   <= '0;
            byte_idx_q  <= '0;
            shift_q     <= '0;
        end else begin
            state_q     <= state_d;
            size_q      <= size_d;
            remaining_q <= remaining_d;
            hdr_cnt_q   <= hdr_cnt_d;
            byte_idx_q  <= byte_idx_d;
            shift_q     <= shift_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        size_d      = size_q;
        remaining_d = remaining_q;
        hdr_cnt_d   = hdr_cnt_q;
        byte_idx_d  = byte_idx_q;
        shift_d     = shift_q;
        word_ready  = 1'b0;
        tx_valid    = 1'b0;
        tx_data     = 8'h00;
        busy        = 1'b1;
        done        = 1'b0;

        unique case (state_q)
            StIdle: begin
                busy = 1'b0;
                if (start) begin
                    size_d      = answer_size_in_bytes;
                    remaining_d = answer_size_in_bytes;
                    hdr_cnt_d   = 2'd3;
                    if (HEADER_EN) begin
                        state_d = StHdr;
                    end else if (answer_size_in_bytes != 32'd0) begin
                        state_d = StLoad;
                    end else begin
                        state_d = StDone;
                    end
                end
            end

            StHdr: begin
                tx_valid = 1'b1;
                // hdr_cnt counts down, so 3 selects the least significant size byte.
                case (hdr_cnt_q)
                    2'd3:    tx_data = size_q[7:0];
                    2'd2:    tx_data = size_q[15:8];
                    2'd1:    tx_data = size_q[23:16];
                    default: tx_data = size_q[31:24];
                endcase
                if (tx_ready) begin
                    if (hdr_cnt_q == 2'd0) begin
                        state_d = (remaining_q != 32'd0) ? StLoad : StDone;
                    end else begin
                        hdr_cnt_d = hdr_cnt_q - 2'd1;
                    end
                end
            end

            StLoad: begin
                word_ready = 1'b1;
                if (word_valid) begin
                    shift_d    = word_data;
                    byte_idx_d = IdxW'(BytesPerWord);
                    state_d    = StSend;
                end
            end

            StSend: begin
                tx_valid = 1'b1;
                tx_data  = shift_q[7:0];
                if (tx_ready) begin
                    shift_d     = shift_q >> 8;
                    remaining_d = remaining_q - 32'd1;
                    byte_idx_d  = byte_idx_q - IdxW'(1);
                    // Final byte wins over word boundary: leftover bytes are dropped.
                    if (remaining_q == 32'd1) begin
                        state_d = StDone;
                    end else if (byte_idx_q == IdxW'(1)) begin
                        state_d = StLoad;
                    end
                end
            end

            StDone: begin
                done    = 1'b1;
                state_d = StIdle;
            end

            default: state_d = StIdle;
        endcase
    end

endmodule

// File: tb/tb_answer_byte_streamer.sv
// Scoreboard bench: a 32-bit/header instance and an 8-bit/no-header instance,
// expected bytes queued at stimulus time and popped on each TX handshake.
module tb_answer_byte_streamer;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst = 1'b1;

    // Instance A: WORD_WIDTH=32, HEADER_EN=1
    logic        a_start = 1'b0;
    logic [31:0] a_size = '0;
    logic [31:0] a_word_data = '0;
    logic        a_word_valid = 1'b0;
    logic        a_word_ready;
    logic [7:0]  a_tx_data;
    logic        a_tx_valid;
    logic        a_tx_ready;
    logic        a_busy;
    logic        a_done;

    // Instance B: WORD_WIDTH=8, HEADER_EN=0
    logic        b_start = 1'b0;
    logic [31:0] b_size = '0;
    logic [7:0]  b_word_data = '0;
    logic        b_word_valid = 1'b0;
    logic        b_word_ready;
    logic [7:0]  b_tx_data;
    logic        b_tx_valid;
    logic        b_tx_ready = 1'b1;
    logic        b_busy;
    logic        b_done;

    answer_byte_streamer u_dut_a (
        .i_clk(clk), .i_rst(rst), .start(a_start), .answer_size_in_bytes(a_size),
        .word_data(a_word_data), .word_valid(a_word_valid), .word_ready(a_word_ready),
        .tx_data(a_tx_data), .tx_valid(a_tx_valid), .tx_ready(a_tx_ready),
        .busy(a_busy), .done(a_done)
    );

    answer_byte_streamer #(.WORD_WIDTH(8), .HEADER_EN(1'b0)) u_dut_b (
        .i_clk(clk), .i_rst(rst), .start(b_start), .answer_size_in_bytes(b_size),
        .word_data(b_word_data), .word_valid(b_word_valid), .word_ready(b_word_ready),
        .tx_data(b_tx_data), .tx_valid(b_tx_valid), .tx_ready(b_tx_ready),
        .busy(b_busy), .done(b_done)
    );

    int checks = 0;
    int errors = 0;

    logic [7:0]  exp_a[$];
    logic [7:0]  exp_b[$];
    logic [31:0] wq_a[$];
    logic [7:0]  wq_b[$];

    int a_words = 0, a_dones = 0, a_bytes = 0, a_wr_cycles = 0;
    int b_words = 0, b_dones = 0, b_valid_cycles = 0;
    logic a_word_hs = 1'b0, b_word_hs = 1'b0;
    logic a_prev_stall = 1'b0;
    logic [7:0] a_prev_data = '0;
    logic [7:0] a_exp_byte, b_exp_byte;

    int a_ready_mode = 0;  // 0: always ready, 1: random, 2: never ready
    bit a_gaps = 1'b0;
    bit a_rand = 1'b0;
    assign a_tx_ready = (a_ready_mode == 0) ? 1'b1 : (a_ready_mode == 2) ? 1'b0 : a_rand;

    // Word sources: pop on the handshake seen at the previous negedge.
    always @(posedge clk) begin
        #1;
        if (a_word_hs && wq_a.size() != 0) wq_a.delete(0);
        a_word_valid = (wq_a.size() != 0) && (!a_gaps || $urandom_range(0, 1) == 1);
        a_word_data  = (wq_a.size() != 0) ? wq_a[0] : 32'h0;
        a_rand       = ($urandom_range(0, 1) == 1);
        if (b_word_hs && wq_b.size() != 0) wq_b.delete(0);
        b_word_valid = (wq_b.size() != 0);
        b_word_data  = (wq_b.size() != 0) ? wq_b[0] : 8'h0;
    end

    // Monitor A
    always @(negedge clk) begin
        a_word_hs = a_word_valid && a_word_ready;
        if (a_word_hs) a_words++;
        if (a_word_ready) a_wr_cycles++;
        if (a_done) a_dones++;
        if (a_prev_stall) begin
            checks++;
            if (!a_tx_valid || a_tx_data !== a_prev_data) begin
                errors++;
                $display("FAIL a_hold_stable got valid=%0b data=%02h expected valid=1 data=%02h",
                         a_tx_valid, a_tx_data, a_prev_data);
            end
        end
        if (a_tx_valid && a_tx_ready) begin
            a_bytes++;
            checks++;
            if (exp_a.size() == 0) begin
                errors++;
                $display("FAIL a_byte got %02h expected no byte", a_tx_data);
            end else begin
                a_exp_byte = exp_a.pop_front();
                if (a_tx_data !== a_exp_byte) begin
                    errors++;
                    $display("FAIL a_byte got %02h expected %02h", a_tx_data, a_exp_byte);
                end
            end
        end
        a_prev_stall = a_tx_valid && !a_tx_ready && !rst;
        a_prev_data  = a_tx_data;
    end

    // Monitor B
    always @(negedge clk) begin
        b_word_hs = b_word_valid && b_word_ready;
        if (b_word_hs) b_words++;
        if (b_done) b_dones++;
        if (b_tx_valid) b_valid_cycles++;
        if (b_tx_valid && b_tx_ready) begin
            checks++;
            if (exp_b.size() == 0) begin
                errors++;
                $display("FAIL b_byte got %02h expected no byte", b_tx_data);
            end else begin
                b_exp_byte = exp_b.pop_front();
                if (b_tx_data !== b_exp_byte) begin
                    errors++;
                    $display("FAIL b_byte got %02h expected %02h", b_tx_data, b_exp_byte);
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog got no finish expected finish");
        $fatal(1, "simulation timeout");
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    // Reference model: header (size LSB first) then payload bytes by index.
    task automatic queue_transfer_a(input logic [31:0] size);
        for (int k = 0; k < 4; k++) exp_a.push_back(8'(size >> (8 * k)));
        for (int i = 0; i < int'(size); i++) exp_a.push_back(8'(wq_a[i / 4] >> (8 * (i % 4))));
    endtask

    task automatic start_a(input logic [31:0] size);
        step();
        a_start = 1'b1;
        a_size  = size;
        step();
        a_start = 1'b0;
    endtask

    task automatic start_b(input logic [31:0] size);
        step();
        b_start = 1'b1;
        b_size  = size;
        step();
        b_start = 1'b0;
    endtask

    task automatic wait_done_a(input int budget, input int base);
        bit ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            #1;
            if (a_dones != base) begin
                ok = 1'b1;
                break;
            end
        end
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL a_done_wait got no done expected done within %0d cycles", budget);
        end
    endtask

    task automatic wait_done_b(input int budget, input int base);
        bit ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            #1;
            if (b_dones != base) begin
                ok = 1'b1;
                break;
            end
        end
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL b_done_wait got no done expected done within %0d cycles", budget);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) step();
        checks++;
        if ({a_tx_data, a_tx_valid, a_word_ready, a_busy, a_done} !== 12'h0) begin
            errors++;
            $display("FAIL reset_a got %03h expected 000",
                     {a_tx_data, a_tx_valid, a_word_ready, a_busy, a_done});
        end
        checks++;
        if ({b_tx_data, b_tx_valid, b_word_ready, b_busy, b_done} !== 12'h0) begin
            errors++;
            $display("FAIL reset_b got %03h expected 000",
                     {b_tx_data, b_tx_valid, b_word_ready, b_busy, b_done});
        end
        rst = 1'b0;
        step();
    endtask

    task automatic test_basic();
        int wbase = a_words;
        int dbase = a_dones;
        wq_a.push_back(32'h44332211);
        wq_a.push_back(32'h88776655);
        queue_transfer_a(32'd8);
        start_a(32'd8);
        checks++;
        if (a_tx_valid !== 1'b1 || a_tx_data !== 8'h08) begin
            errors++;
            $display("FAIL basic_latency got valid=%0b data=%02h expected valid=1 data=08",
                     a_tx_valid, a_tx_data);
        end
        wait_done_a(200, dbase);
        @(negedge clk);
        #1;
        checks++;
        if (a_busy !== 1'b0 || a_done !== 1'b0) begin
            errors++;
            $display("FAIL basic_after_done got busy=%0b done=%0b expected 0 0", a_busy, a_done);
        end
        checks++;
        if (exp_a.size() != 0 || a_words - wbase != 2 || a_dones - dbase != 1) begin
            errors++;
            $display("FAIL basic_counts got left=%0d words=%0d dones=%0d expected 0 2 1",
                     exp_a.size(), a_words - wbase, a_dones - dbase);
        end
    endtask

    task automatic test_partial();
        int wbase = a_words;
        int dbase = a_dones;
        wq_a.push_back(32'hDDCCBBAA);
        wq_a.push_back(32'h0000FFEE);
        queue_transfer_a(32'd6);
        start_a(32'd6);
        wait_done_a(200, dbase);
        step();
        checks++;
        if (exp_a.size() != 0 || a_words - wbase != 2 || wq_a.size() != 0) begin
            errors++;
            $display("FAIL partial got left=%0d words=%0d queued=%0d expected 0 2 0",
                     exp_a.size(), a_words - wbase, wq_a.size());
        end
    endtask

    task automatic test_zero_size();
        int rbase = a_wr_cycles;
        int dbase = a_dones;
        int vbase = b_valid_cycles;
        queue_transfer_a(32'd0);
        start_a(32'd0);
        wait_done_a(100, dbase);
        step();
        checks++;
        if (exp_a.size() != 0 || a_wr_cycles != rbase) begin
            errors++;
            $display("FAIL zero_hdr got left=%0d ready_cycles=%0d expected 0 0",
                     exp_a.size(), a_wr_cycles - rbase);
        end
        // Start sampled at one edge; DONE is the following cycle.
        start_b(32'd0);
        checks++;
        if (b_done !== 1'b1 || b_busy !== 1'b1) begin
            errors++;
            $display("FAIL zero_nohdr_done got done=%0b busy=%0b expected 1 1", b_done, b_busy);
        end
        step();
        checks++;
        if (b_done !== 1'b0 || b_busy !== 1'b0 || b_valid_cycles != vbase) begin
            errors++;
            $display("FAIL zero_nohdr_after got done=%0b busy=%0b valid_cycles=%0d expected 0 0 0",
                     b_done, b_busy, b_valid_cycles - vbase);
        end
    endtask

    task automatic test_random();
        int wbase = a_words;
        int dbase = a_dones;
        for (int i = 0; i < 10; i++) wq_a.push_back($urandom);
        queue_transfer_a(32'd37);
        a_ready_mode = 1;
        a_gaps       = 1'b1;
        start_a(32'd37);
        wait_done_a(3000, dbase);
        a_ready_mode = 0;
        a_gaps       = 1'b0;
        step();
        checks++;
        if (exp_a.size() != 0 || a_words - wbase != 10) begin
            errors++;
            $display("FAIL random got left=%0d words=%0d expected 0 10",
                     exp_a.size(), a_words - wbase);
        end
    endtask

    task automatic test_ignore_start();
        int wbase = a_words;
        int dbase = a_dones;
        for (int i = 0; i < 3; i++) wq_a.push_back($urandom);
        queue_transfer_a(32'd10);
        a_ready_mode = 1;
        start_a(32'd10);
        repeat (5) step();
        a_start = 1'b1;
        a_size  = 32'd99;
        step();
        a_start = 1'b0;
        a_size  = 32'hDEAD;
        wait_done_a(1000, dbase);
        // Start during the DONE cycle must also be ignored.
        a_start = 1'b1;
        a_size  = 32'd5;
        step();
        a_start = 1'b0;
        a_ready_mode = 0;
        checks++;
        if (a_busy !== 1'b0 || a_tx_valid !== 1'b0) begin
            errors++;
            $display("FAIL ignore_done_start got busy=%0b valid=%0b expected 0 0",
                     a_busy, a_tx_valid);
        end
        checks++;
        if (exp_a.size() != 0 || a_words - wbase != 3) begin
            errors++;
            $display("FAIL ignore_count got left=%0d words=%0d expected 0 3",
                     exp_a.size(), a_words - wbase);
        end
    endtask

    task automatic test_reset_mid();
        int bbase = a_bytes;
        int dbase;
        bit hit = 1'b0;
        wq_a.push_back(32'h44332211);
        wq_a.push_back(32'h88776655);
        queue_transfer_a(32'd8);
        start_a(32'd8);
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            #1;
            if (a_bytes - bbase == 7) begin
                hit = 1'b1;
                break;
            end
        end
        checks++;
        if (!hit) begin
            errors++;
            $display("FAIL reset_mid_progress got bytes=%0d expected 7", a_bytes - bbase);
        end
        step();
        rst          = 1'b1;
        a_ready_mode = 2;
        exp_a.delete();
        wq_a.delete();
        step();
        checks++;
        if ({a_tx_data, a_tx_valid, a_word_ready, a_busy, a_done} !== 12'h0) begin
            errors++;
            $display("FAIL reset_mid_outputs got %03h expected 000",
                     {a_tx_data, a_tx_valid, a_word_ready, a_busy, a_done});
        end
        rst          = 1'b0;
        a_ready_mode = 0;
        step();
        dbase = a_dones;
        wq_a.push_back(32'hCAFEBABE);
        queue_transfer_a(32'd4);
        start_a(32'd4);
        wait_done_a(200, dbase);
        step();
        checks++;
        if (exp_a.size() != 0) begin
            errors++;
            $display("FAIL reset_mid_restart got left=%0d expected 0", exp_a.size());
        end
    endtask

    task automatic test_narrow();
        int wbase = b_words;
        int dbase = b_dones;
        wq_b.push_back(8'h5A);
        wq_b.push_back(8'hC3);
        wq_b.push_back(8'h7E);
        wq_b.push_back(8'h11);
        for (int i = 0; i < 3; i++) exp_b.push_back(wq_b[i]);
        start_b(32'd3);
        wait_done_b(100, dbase);
        step();
        checks++;
        if (exp_b.size() != 0 || b_words - wbase != 3 || wq_b.size() != 1) begin
            errors++;
            $display("FAIL narrow got left=%0d words=%0d queued=%0d expected 0 3 1",
                     exp_b.size(), b_words - wbase, wq_b.size());
        end
        wq_b.delete();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_partial();
        test_zero_size();
        test_random();
        test_ignore_start();
        test_reset_mid();
        test_narrow();
        repeat (3) step();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
